// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter/sequencer for the shared RAM data port: SELECT then ACCESS pipeline.
// Define RAM_ARB_FIXED_PRIORITY_EN to make r0 win every tie instead of round-robin.
module ram_port_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  r0_req,
    input  logic                  r0_wEn,
    input  logic [ADDR_WIDTH-1:0] r0_address,
    input  logic [DATA_WIDTH-1:0] r0_write_data,
    output logic                  r0_gnt,
    output logic                  r0_valid,
    output logic [DATA_WIDTH-1:0] r0_read_data,
    input  logic                  r1_req,
    input  logic                  r1_wEn,
    input  logic [ADDR_WIDTH-1:0] r1_address,
    input  logic [DATA_WIDTH-1:0] r1_write_data,
    output logic                  r1_gnt,
    output logic                  r1_valid,
    output logic [DATA_WIDTH-1:0] r1_read_data,
    output logic                  wEn,
    output logic [ADDR_WIDTH-1:0] d_address,
    output logic [DATA_WIDTH-1:0] d_write_data,
    input  logic [DATA_WIDTH-1:0] d_read_data
);

    logic                  r0_gnt_q, r1_gnt_q;
    logic                  r0_valid_q, r1_valid_q;
    logic [DATA_WIDTH-1:0] r0_read_data_q, r1_read_data_q;
    logic                  wen_q;
    logic [ADDR_WIDTH-1:0] d_address_q;
    logic [DATA_WIDTH-1:0] d_write_data_q;
    logic                  acc_busy_q;
    logic                  acc_owner_q;
`ifndef RAM_ARB_FIXED_PRIORITY_EN
    logic                  last_grant_q;
`endif

    logic elig0, elig1, win0, win1;

    // A requester is ignored in its own gnt cycle, so holding req one extra cycle is harmless.
    always_comb begin
        elig0 = r0_req & ~r0_gnt_q;
        elig1 = r1_req & ~r1_gnt_q;
`ifdef RAM_ARB_FIXED_PRIORITY_EN
        win0  = elig0;
        win1  = elig1 & ~elig0;
`else
        win0  = elig0 & (~elig1 | last_grant_q);
        win1  = elig1 & (~elig0 | ~last_grant_q);
`endif
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r0_gnt_q       <= 1'b0;
            r1_gnt_q       <= 1'b0;
            r0_valid_q     <= 1'b0;
            r1_valid_q     <= 1'b0;
            r0_read_data_q <= '0;
            r1_read_data_q <= '0;
            wen_q          <= 1'b0;
            d_address_q    <= '0;
            d_write_data_q <= '0;
            acc_busy_q     <= 1'b0;
            acc_owner_q    <= 1'b0;
`ifndef RAM_ARB_FIXED_PRIORITY_EN
            last_grant_q   <= 1'b1;
`endif
        end else begin
            r0_gnt_q   <= win0;
            r1_gnt_q   <= win1;
            acc_busy_q <= win0 | win1;
            if (win0 | win1) begin
                acc_owner_q    <= win1;
                wen_q          <= win1 ? r1_wEn : r0_wEn;
                d_address_q    <= win1 ? r1_address : r0_address;
                d_write_data_q <= win1 ? r1_write_data : r0_write_data;
`ifndef RAM_ARB_FIXED_PRIORITY_EN
                last_grant_q   <= win1;
`endif
            end else begin
                wen_q <= 1'b0;
            end
            // ACCESS completes here; a write returns the pre-write contents.
            r0_valid_q <= acc_busy_q & ~acc_owner_q;
            r1_valid_q <= acc_busy_q & acc_owner_q;
            if (acc_busy_q && !acc_owner_q) r0_read_data_q <= d_read_data;
            if (acc_busy_q && acc_owner_q)  r1_read_data_q <= d_read_data;
        end
    end

    assign r0_gnt       = r0_gnt_q;
    assign r1_gnt       = r1_gnt_q;
    assign r0_valid     = r0_valid_q;
    assign r1_valid     = r1_valid_q;
    assign r0_read_data = r0_read_data_q;
    assign r1_read_data = r1_read_data_q;
    // Reset low during an ACCESS cycle must not let a write reach the RAM.
    assign wEn          = wen_q & reset;
    assign d_address    = d_address_q;
    assign d_write_data = d_write_data_q;

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester arbiter and sequencer for the data port of the shared `ram` (DATA_WIDTH 32, ADDR_WIDTH 16). It sits between the `ram` data port and two masters: requester 0, the core memory stage, and requester 1, the loader/debug path. It accepts at most one command per cycle and drives registered `wEn`, `d_address` and `d_write_data` to the RAM. It returns the read data and a completion pulse to the owning requester. The `ram` instruction port is not touched by this block.

## Interface
- DATA_WIDTH, 32, data word width; matches `ram`.
- ADDR_WIDTH, 16, byte address width; matches `ram`.

- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- r0_req, r1_req  in  1  command request; held with fields stable until the matching gnt.
- r0_wEn, r1_wEn  in  1  1 = write, 0 = read.
- r0_address, r1_address  in  ADDR_WIDTH  byte address; passed to the RAM unchanged.
- r0_write_data, r1_write_data  in  DATA_WIDTH  write data.
- r0_gnt, r1_gnt  out  1  one-cycle pulse: command accepted.
- r0_valid, r1_valid  out  1  one-cycle pulse: access complete.
- r0_read_data, r1_read_data  out  DATA_WIDTH  registered response; holds its value between valid pulses.
- wEn  out  1  RAM write enable.
- d_address  out  ADDR_WIDTH  RAM data address.
- d_write_data  out  DATA_WIDTH  RAM write data.
- d_read_data  in  DATA_WIDTH  RAM data read; combinational from d_address.

## Operation
- Two-stage pipeline:
  - SELECT stage: arbitrates the requests and latches the winner's command into the RAM-side registers.
  - ACCESS stage: the command is applied to the RAM, `d_read_data` is sampled, and the result is returned to the owner.
- Pipeline state registers:
  - `acc_busy`: an ACCESS is in flight.
  - `acc_owner`: which requester owns the in-flight access.
  - `last_grant`: arbitration history.
- Eligibility: requester X is eligible when rX_req=1 and rX_gnt=0 in that cycle. A requester ignores its own req during its gnt cycle, so it can still hold req for one cycle after acceptance.
- Arbitration:
  - Only one eligible requester: it wins.
  - Both eligible: the requester not equal to `last_grant` wins (round-robin).
  - `last_grant` updates to the winner on every grant.
- Accepting a command at edge E:
  - RAM-side registers load the command.
  - rX_gnt=1 for the following cycle.
  - acc_busy=1 and acc_owner=X.
- With no winner at edge E: acc_busy=0, internal wEn register=0, d_address and d_write_data hold their values.
- At the edge ending the ACCESS cycle:
  - rOwner_read_data <= d_read_data.
  - rOwner_valid=1 for the next cycle.
  - A write commits in the RAM at this same edge.
  - For a write, read_data captures the pre-write contents of the address.
- Output gating: `wEn` = internal wEn register AND reset. A write whose ACCESS cycle coincides with reset=0 is suppressed.
- Reset (reset=0 at an edge):
  - All gnt, valid and wEn outputs go to 0; d_address and d_write_data go to 0.
  - r0_read_data and r1_read_data go to 0.
  - acc_busy=0 and last_grant=1, so r0 wins the first tie.
  - An in-flight access is abandoned and produces no valid pulse.

## Timing
- Cycle N: rX_req sampled; grant at edge ending N.
- Cycle N+1: rX_gnt=1; RAM sees the command; new SELECT proceeds in parallel.
- Cycle N+2: rX_valid=1 with rX_read_data. Latency from req to valid is 2 cycles.
- Throughput:
  - Alternating requesters: one access per cycle.
  - A single requester holding req continuously: one access every 2 cycles.
- Simultaneous gnt and valid to the same requester in one cycle is legal and occurs in the alternating case.

## Configuration
- `RAM_ARB_FIXED_PRIORITY_EN` defined: when both requesters are eligible, r0 always wins; `last_grant` is not used for tie-breaks. r1 still progresses, because r0 is ineligible in its own gnt cycles.
- Undefined (default): round-robin as specified above.

## Test plan
- Reset and single write/read: after reset is held low for 2 cycles, r0 writes 0x00000001 to address 4, then reads address 4.
  - Required: r0_gnt in N+1 and r0_valid in N+2 for each command.
  - Required: wEn=1 for exactly one cycle; the read returns 0x00000001.
- Tie round-robin: both requesters continuously read addresses 4 and 8 (preloaded 0x1 and 0x2).
  - Required grant order: r0, r1, r0, r1, with one gnt per cycle.
  - Required: r0 always gets 0x1 and r1 always gets 0x2.
- Single requester back-to-back: r1 holds req for 6 cycles.
  - Required: r1_gnt pulses every other cycle, i.e. 3 grants.
- Write/read same address across requesters: r0 writes 0x8 to address 8 and r1 reads address 8 in the next cycle.
  - Required: r0_read_data=old value; r1_read_data=0x00000008.
- Reset mid-access: r1 write of 0x10 to address 4, with reset=0 during its ACCESS cycle.
  - Required: wEn stays 0 and there is no r1_valid.
  - Required: a later read of address 4 returns its previous value.
- With `RAM_ARB_FIXED_PRIORITY_EN`, both requesters requesting continuously:
  - Required: r0 wins every cycle in which it is eligible; grant order is r0, r1, r0, r1.
